// File: rtl/rand_arbiter_pkg.sv
// Shared types and default constants for the random-source arbiter and its helpers.
package rand_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    SAMPLE,
    GRANT
  } state_t;

  localparam int N_REQ_DEF     = 4;
  localparam int WIDTH_DEF     = 9;
  localparam int RANGE_DEF     = 400;
  localparam int MAX_RETRY_DEF = 3;
  localparam int STAT_W        = 16;

endpackage

// File: rtl/rand_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selection of the first set request at or after ptr.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  int j;

  // Walk offsets from the far end so the smallest offset from ptr is the last write and wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/rand_arbiter.sv
// rand_arbiter: shares one LFSR among N_REQ requesters, range-reducing samples by bounded rejection.
// Optional saturating statistics counters are enabled with `define RAND_ARBITER_STATS_EN.
module rand_arbiter
  import rand_arbiter_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int WIDTH     = WIDTH_DEF,
  parameter int RANGE     = RANGE_DEF,
  parameter int MAX_RETRY = MAX_RETRY_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REQ-1:0]  req,
  input  logic [WIDTH-1:0]  lfsr_in,
  output logic              lfsr_step,
  output logic [N_REQ-1:0]  ack,
  output logic [WIDTH-1:0]  rand_out,
`ifdef RAND_ARBITER_STATS_EN
  output logic [STAT_W-1:0] reject_cnt,
  output logic [7:0]        fold_cnt,
`endif
  output logic              busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int RET_W = $clog2(MAX_RETRY + 2);
  localparam logic [WIDTH:0]   RANGE_EXT = (WIDTH + 1)'(RANGE);
  localparam logic [WIDTH-1:0] RANGE_W   = WIDTH'(RANGE);
  localparam logic [RET_W-1:0] RETRY_MAX = RET_W'(MAX_RETRY);
  // Subtracting RANGE once only lands inside the range when RANGE is above half the sample space.
  localparam bit FOLD_MOD = (2 * RANGE <= (1 << WIDTH));

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, gnt, gnt_inc;
  logic [RET_W-1:0] retry;
  logic [WIDTH-1:0] cap, rand_q, fold_val;
  logic             pick_valid, in_range, retry_left;
  logic [IDX_W-1:0] pick_idx;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign in_range   = {1'b0, lfsr_in} < RANGE_EXT;
  assign retry_left = retry < RETRY_MAX;
  assign gnt_inc    = (gnt == IDX_W'(N_REQ - 1)) ? '0 : gnt + IDX_W'(1);

  always_comb begin
    fold_val = lfsr_in - RANGE_W;
    if (FOLD_MOD) fold_val = fold_val % RANGE_W;
  end

  // NOTE: all registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = STEP;
      STEP:    state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (in_range || !retry_left) ? GRANT : STEP;
      GRANT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr    <= '0;
      gnt    <= '0;
      retry  <= '0;
      cap    <= '0;
      rand_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt   <= pick_idx;
            retry <= '0;
          end
        end
        SAMPLE: begin
          if (in_range)        cap   <= lfsr_in;
          else if (retry_left) retry <= retry + RET_W'(1);
          else                 cap   <= fold_val;
        end
        GRANT: begin
          ptr <= gnt_inc;
          if (req[gnt]) rand_q <= cap;
        end
        default: ;
      endcase
    end
  end

  // A withdrawn requester gets no ack and its value never reaches rand_out.
  always_comb begin
    lfsr_step = (state == STEP);
    busy      = (state != IDLE);
    ack       = '0;
    rand_out  = rand_q;
    if (state == GRANT && req[gnt]) begin
      ack[gnt] = 1'b1;
      rand_out = cap;
    end
  end

`ifdef RAND_ARBITER_STATS_EN
  logic reject_ev, fold_ev;

  assign reject_ev = (state == SAMPLE) && !in_range && retry_left;
  assign fold_ev   = (state == SAMPLE) && !in_range && !retry_left;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reject_cnt <= '0;
      fold_cnt   <= '0;
    end else begin
      if (reject_ev && reject_cnt != '1) reject_cnt <= reject_cnt + STAT_W'(1);
      if (fold_ev && fold_cnt != '1)     fold_cnt   <= fold_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rand_arbiter.sv
// Self-checking bench for rand_arbiter: directed scenarios plus randomized traffic against a transaction model.
module tb_rand_arbiter;

  localparam int N     = 4;
  localparam int W     = 9;
  localparam int RANGE = 400;
  localparam int MAXR  = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] req = '0;
  logic [W-1:0] lfsr_in;
  logic         lfsr_step;
  logic [N-1:0] ack;
  logic [W-1:0] rand_out;
  logic         busy;
`ifdef RAND_ARBITER_STATS_EN
  logic [15:0]  reject_cnt;
  logic [7:0]   fold_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int m_ptr   = 0;
  int sample_q[$];
  int plan_q[$];
  bit step_seen;

  rand_arbiter #(
    .N_REQ     (N),
    .WIDTH     (W),
    .RANGE     (RANGE),
    .MAX_RETRY (MAXR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .lfsr_in   (lfsr_in),
    .lfsr_step (lfsr_step),
    .ack       (ack),
    .rand_out  (rand_out),
`ifdef RAND_ARBITER_STATS_EN
    .reject_cnt(reject_cnt),
    .fold_cnt  (fold_cnt),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // LFSR stand-in: presents the next planned sample one cycle after each step pulse.
  initial begin
    lfsr_in = '0;
    forever begin
      @(negedge clk);
      step_seen = lfsr_step;
      @(posedge clk);
      #1;
      if (step_seen) lfsr_in = (sample_q.size() > 0) ? W'(sample_q.pop_front()) : W'($urandom);
    end
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic gen_plan();
    int s;
    plan_q.delete();
    for (int k = 0; k <= MAXR; k++) begin
      s = ($urandom_range(0, 1) == 1) ? int'($urandom_range(RANGE, 511)) : int'($urandom_range(0, RANGE - 1));
      plan_q.push_back(s);
      if (s < RANGE) break;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req   = '0;
    sample_q.delete();
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_step", lfsr_step, 0);
    check("rst_rand_out", rand_out, 0);
    reset = 1'b1;
    m_ptr = 0;
  endtask

  // Presents r to an idle arbiter, consumes plan_q as the sample stream and checks the grant.
  task automatic do_txn(input logic [N-1:0] r, input string tag, output int w, output logic [N-1:0] ack_seen);
    int  val, rej, steps, c;
    bit  got;
    w = -1;
    for (int i = 0; i < N; i++)
      if (w < 0 && r[(m_ptr + i) % N]) w = (m_ptr + i) % N;
    val = 0;
    rej = 0;
    for (int k = 0; k < plan_q.size(); k++) begin
      rej = k;
      if (plan_q[k] < RANGE) begin
        val = plan_q[k];
        break;
      end
      val = plan_q[k] - RANGE;
      if (2 * RANGE <= 512) val = val % RANGE;
    end
    foreach (plan_q[k]) sample_q.push_back(plan_q[k]);
    plan_q.delete();
    @(posedge clk);
    #1;
    req   = r;
    steps = 0;
    got   = 0;
    ack_seen = '0;
    for (c = 0; c < 40; c++) begin
      @(negedge clk);
      if (lfsr_step) steps++;
      if (ack != 0) begin
        got = 1;
        ack_seen = ack;
        break;
      end
    end
    check({tag, "_seen"}, got, 1);
    check({tag, "_latency"}, c, 3 + 2 * rej);
    check({tag, "_ack"}, ack, 1 << w);
    check({tag, "_value"}, rand_out, val);
    check({tag, "_steps"}, steps, rej + 1);
    check({tag, "_lt_range"}, (rand_out < RANGE), 1);
    m_ptr = (w + 1) % N;
  endtask

  initial begin
    int w;
    logic [N-1:0] a, r, pending;
    int cnt;

    do_reset();

    plan_q = '{123};
    do_txn(4'b0001, "single", w, a);
    @(posedge clk);
    #1;
    req = '0;
    @(negedge clk);
    check("single_idle_busy", busy, 0);
    check("single_hold", rand_out, 123);
    check("single_idle_ack", ack, 0);

    plan_q = '{450, 17};
    do_txn(4'b0001, "reject1", w, a);

    plan_q = '{500, 480, 410, 499};
    do_txn(4'b0001, "exhaust", w, a);
    check("exhaust_value99", rand_out, 99);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      gen_plan();
      do_txn(4'b1111, "rr", w, a);
      check("rr_order", a, 1 << (i % N));
    end

    // Withdrawn request: req[2] drops during SAMPLE, req[3] stays pending.
    do_reset();
    sample_q.push_back(55);
    @(posedge clk);
    #1;
    req = 4'b1100;
    @(negedge clk);
    @(negedge clk);
    check("wd_step", lfsr_step, 1);
    @(posedge clk);
    #2;
    req = 4'b1000;
    @(negedge clk);
    check("wd_sample_ack", ack, 0);
    @(negedge clk);
    check("wd_grant_noack", ack, 0);
    check("wd_grant_busy", busy, 1);
    sample_q.push_back(77);
    cnt = 0;
    a   = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ack != 0) begin
        cnt = c;
        a   = ack;
        break;
      end
    end
    check("wd_next_ack", a, 4'b1000);
    check("wd_next_latency", cnt, 4);
    check("wd_next_value", rand_out, 77);
    check("wd_hold_after_discard", (rand_out != 55), 1);
    m_ptr = 0;

    // Async reset between edges while in SAMPLE.
    do_reset();
    sample_q.push_back(200);
    @(posedge clk);
    #1;
    req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_ack", ack, 0);
    check("arst_step", lfsr_step, 0);
    req = '0;
    sample_q.delete();
    @(negedge clk);
    reset = 1'b1;
    m_ptr = 0;
    plan_q = '{300};
    do_txn(4'b0001, "arst_after", w, a);

    // Randomized traffic: held requests accumulate, the served one is dropped after its ack.
    pending = '0;
    for (int i = 0; i < 40; i++) begin
      r = pending | N'($urandom_range(0, 15));
      if (r == 0) r = N'(1 << $urandom_range(0, N - 1));
      gen_plan();
      do_txn(r, "rand", w, a);
      pending = r & ~N'(1 << w);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rand_arbiter.md
Name: rand_arbiter

Overview:
- Shares the single 9-bit LFSR random source among N_REQ requesters: cube spawners, colour picker and speed jitter.
- Advances the LFSR on demand and range-reduces each sample to 0..RANGE-1 by rejection with bounded retries.
- Returns one value per grant, round-robin fair.
- Sits between the LFSR instance and the FallingCubes game logic.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 9, LFSR/result width in bits.
- RANGE, 400, exclusive upper bound of delivered values (1..2^WIDTH).
- MAX_RETRY, 3, rejected samples tolerated before folding.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  level request per requester; held until its ack.
- lfsr_in  in  WIDTH  current LFSR state; updates the cycle after lfsr_step.
- lfsr_step  out  1  one-cycle pulse advancing the LFSR one step.
- ack  out  N_REQ  one-hot, one-cycle pulse; rand_out is valid in that cycle.
- rand_out  out  WIDTH  delivered value, always < RANGE.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset=0, async): state=IDLE, ptr=0, retry=0, gnt=0, lfsr_step=0, ack=0, rand_out=0, busy=0.
- IDLE: if any req bit is set, pick the first set bit at or after ptr, cyclically. Latch gnt, clear retry, go to STEP.
- STEP: lfsr_step=1 for exactly this cycle, then go to SAMPLE.
- SAMPLE: read lfsr_in.
  - If lfsr_in < RANGE: capture it, go to GRANT.
  - Else if retry < MAX_RETRY: retry++, go to STEP.
  - Else capture lfsr_in - RANGE (unsigned, WIDTH bits), go to GRANT. If RANGE <= 2^WIDTH/2, the folded value is still checked and folded modulo RANGE combinationally.
- GRANT:
  - If req[gnt] is still 1: ack[gnt]=1 and rand_out=captured value for one cycle.
  - If req[gnt] has dropped: no ack, value discarded.
  - In both cases ptr <= (gnt+1) mod N_REQ, go to IDLE.
- rand_out holds its last delivered value between grants.
- Latency from req high in IDLE to ack: 3 cycles with no rejection; +2 cycles per rejection; worst case 3 + 2*MAX_RETRY.
- Simultaneous requests are served one per grant in round-robin order. A requester re-asserting right after its ack goes to the back of the order.
- Requests arriving while busy wait; they are never lost while held.
- An all-zero lfsr_in is passed through like any value; the LFSR guarantees non-lockup.
- Reset mid-operation aborts immediately: no ack, no lfsr_step, state IDLE.

Optional Feature:
- Macro RAND_ARBITER_STATS_EN.
- Defined:
  - Adds output reject_cnt [15:0], counting SAMPLE-state rejections; saturates at 16'hFFFF and clears on reset.
  - Adds output fold_cnt [7:0], counting folded deliveries; saturating.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package rand_arbiter_pkg:
  - state typedef {IDLE, STEP, SAMPLE, GRANT};
  - default constants for N_REQ, WIDTH, RANGE, MAX_RETRY;
  - STAT_W=16.
- One sub-module, rr_picker: combinational round-robin selection taking (req, ptr) and returning (valid, idx). Reused later by the score/sound arbiter.
- FSM, retry counter and capture register stay in rand_arbiter.

Test Plan:
- Single request, no rejection: reset, then req=4'b0001 with lfsr_in=9'd123 after step. Expect lfsr_step pulse at cycle 1, ack=4'b0001 at cycle 3, rand_out=123, busy low at cycle 4.
- Rejection then accept: samples 450, then 17. Expect 2 lfsr_step pulses, ack at cycle 5, rand_out=17.
- Retry exhaustion: samples 500, 480, 410, 499 with MAX_RETRY=3. Expect 4 steps, ack at cycle 9, rand_out=99.
- Round-robin fairness: req=4'b1111 held throughout. Expect acks in order 0001, 0010, 0100, 1000, 0001; each value < 400.
- Withdrawn request: req[2] drops during SAMPLE. Expect no ack, ptr advances to 3, and a pending req[3] is served next.
- Async reset mid-SAMPLE: assert reset low between clock edges. Expect busy, ack and lfsr_step at 0 immediately. After release with req=0001, ack arrives 3 cycles later.
